// File: rtl/traffic_interval_timer.sv
// ---------------------------------------------------------------------------
// traffic_interval_timer
//
// Interval countdown timer for the traffic light controller. When the FSM
// pulses Start_Timer, the 4-bit interval `value` (seconds) is captured. The
// timer then counts it down on an internally divided one-second tick, and
// returns a single-cycle Expired pulse when the interval has elapsed.
// A Prog_Sync strobe aborts any count in progress without pulsing Expired.
//
// Parameters:
//   TICK_DIV   clk cycles per one-second tick (>= 2)
//   DIV_W      divider counter width, 2**DIV_W >= TICK_DIV
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   Hold         (TIMER_HOLD_EN only) freezes an active count while high
//   Start_Timer  single-cycle start/restart request
//   value        interval length in seconds, valid with Start_Timer
//   Prog_Sync    synchronized reprogram strobe, aborts the count
//   Expired      single-cycle pulse on interval completion
//   Busy         high while counting
//   Remaining    seconds left in the current count, 0 when idle
//   One_Hz       one-cycle tick pulse, only while counting
//
// Optional feature macro: TIMER_HOLD_EN (adds the Hold input).
// ---------------------------------------------------------------------------
module traffic_interval_timer #(
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 24
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TIMER_HOLD_EN
    input  logic       Hold,
`endif
    input  logic       Start_Timer,
    input  logic [3:0] value,
    input  logic       Prog_Sync,
    output logic       Expired,
    output logic       Busy,
    output logic [3:0] Remaining,
    output logic       One_Hz
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    state_e           state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             expired_q,   expired_d;
    logic             one_hz_q,    one_hz_d;
    logic             hold_w;

`ifdef TIMER_HOLD_EN
    assign hold_w = Hold;
`else
    assign hold_w = 1'b0;
`endif

    // Decision order encodes the priority: abort, then start/restart,
    // then normal counting. A start on the terminal tick therefore reloads
    // instead of expiring.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        one_hz_d    = 1'b0;

        if (Prog_Sync) begin
            state_d     = IDLE;
            div_d       = '0;
            remaining_d = 4'd0;
        end else if (Start_Timer) begin
            div_d = '0;
            if (value == 4'd0) begin
                // Zero-length interval completes immediately, no COUNT phase.
                state_d     = IDLE;
                remaining_d = 4'd0;
                expired_d   = 1'b1;
            end else begin
                state_d     = COUNT;
                remaining_d = value;
            end
        end else if (state_q == COUNT) begin
            if (!hold_w) begin
                if (div_q == DIV_MAX) begin
                    div_d    = '0;
                    one_hz_d = 1'b1;
                    // Terminal second exits at 1, so the decrement never wraps.
                    if (remaining_q == 4'd1) begin
                        state_d     = IDLE;
                        remaining_d = 4'd0;
                        expired_d   = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        end else begin
            div_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            remaining_q <= 4'd0;
            expired_q   <= 1'b0;
            one_hz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            one_hz_q    <= one_hz_d;
        end
    end

    assign Expired   = expired_q;
    assign Busy      = (state_q == COUNT);
    assign Remaining = remaining_q;
    assign One_Hz    = one_hz_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_traffic_interval_timer
//
// Self-checking bench for traffic_interval_timer with TICK_DIV=4.
// The reference model tracks only "seconds requested" and "cycles elapsed
// since start". It derives Remaining, One_Hz and Expired from those two
// numbers with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_traffic_interval_timer;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       Start_Timer;
    logic [3:0] value;
    logic       Prog_Sync;
    logic       Expired;
    logic       Busy;
    logic [3:0] Remaining;
    logic       One_Hz;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_active;
    int m_n;
    int m_k;
    bit m_exp;
    bit m_hz;

    traffic_interval_timer #(
        .TICK_DIV (TD),
        .DIV_W    (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Start_Timer (Start_Timer),
        .value       (value),
        .Prog_Sync   (Prog_Sync),
        .Expired     (Expired),
        .Busy        (Busy),
        .Remaining   (Remaining),
        .One_Hz      (One_Hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0;
        m_n      = 0;
        m_k      = 0;
        m_exp    = 0;
        m_hz     = 0;
    endtask

    // One clock edge of the reference behaviour, given the sampled inputs.
    task automatic model_edge(input bit st, input int v, input bit pg);
        m_exp = 0;
        m_hz  = 0;
        if (pg) begin
            m_active = 0;
        end else if (st) begin
            if (v == 0) begin
                m_active = 0;
                m_exp    = 1;
            end else begin
                m_active = 1;
                m_n      = v;
                m_k      = 0;
            end
        end else if (m_active) begin
            m_k  = m_k + 1;
            m_hz = (m_k % TD) == 0;
            if (m_k == m_n * TD) begin
                m_active = 0;
                m_exp    = 1;
            end
        end
    endtask

    function automatic logic [6:0] model_vec();
        logic [3:0] rem;
        rem = m_active ? 4'(m_n - m_k / TD) : 4'd0;
        return {m_exp, m_active, rem, m_hz};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {Expired, Busy, Remaining, One_Hz};
    endfunction

    // Drive inputs for one edge, advance the model, sample 1 ns after the edge.
    task automatic step(input bit st, input logic [3:0] v, input bit pg);
        Start_Timer = st;
        value       = v;
        Prog_Sync   = pg;
        @(posedge clk);
        model_edge(st, int'(v), pg);
        #1;
        Start_Timer = 1'b0;
        value       = 4'd0;
        Prog_Sync   = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 4'd5, 0);
        for (int i = 0; i < 3; i++) step(0, 4'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Expired, Busy, Remaining, One_Hz} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got E=%b B=%b R=%0d H=%b required all 0",
                     Expired, Busy, Remaining, One_Hz);
        end
        #3;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step(0, 4'd0, 0);
            checks++;
            if (Expired !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %b required %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_rem;
        step(1, 4'd3, 0);
        for (int e = 0; e <= 14; e++) begin
            if (e > 0) step(0, 4'd0, 0);
            exp_rem = (e <= 12) ? 4'(3 - e / 4) : 4'd0;
            checks++;
            if (Remaining !== exp_rem || One_Hz !== (e > 0 && e <= 12 && e % 4 == 0) ||
                Expired !== (e == 12) || Busy !== (e < 12)) begin
                errors++;
                $display("FAIL basic edge %0d: got R=%0d H=%b E=%b B=%b required R=%0d",
                         e, Remaining, One_Hz, Expired, Busy, exp_rem);
            end
        end
    endtask

    task automatic test_zero();
        step(1, 4'd0, 0);
        checks++;
        if (Expired !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL zero edge0: got E=%b B=%b required E=1 B=0", Expired, Busy);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 4'd0, 0);
            checks++;
            if (Expired !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL zero after: got E=%b B=%b required E=0 B=0", Expired, Busy);
            end
        end
    endtask

    task automatic test_restart();
        step(1, 4'd5, 0);
        for (int e = 1; e <= 16; e++) begin
            step(e == 6, (e == 6) ? 4'd2 : 4'd0, 0);
            checks++;
            if (Expired !== (e == 14) || (e == 6 && Remaining !== 4'd2) ||
                dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL restart edge %0d: got %b required %b", e, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_abort();
        step(1, 4'd11, 0);
        for (int e = 1; e <= 8; e++) step(0, 4'd0, 0);
        step(0, 4'd0, 1);
        checks++;
        if (Remaining !== 4'd0 || Busy !== 1'b0 || Expired !== 1'b0) begin
            errors++;
            $display("FAIL abort edge9: got R=%0d B=%b E=%b required 0 0 0",
                     Remaining, Busy, Expired);
        end
        for (int i = 0; i < 60; i++) begin
            step(0, 4'd0, 0);
            checks++;
            if (Expired !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL abort_quiet cyc %0d: got %b required %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_priority();
        step(1, 4'd4, 1);
        checks++;
        if (Busy !== 1'b0 || Remaining !== 4'd0 || Expired !== 1'b0) begin
            errors++;
            $display("FAIL prio_prog: got B=%b R=%0d E=%b required 0 0 0", Busy, Remaining, Expired);
        end
        step(1, 4'd1, 0);
        for (int e = 1; e <= 13; e++) begin
            step(e == 4, (e == 4) ? 4'd2 : 4'd0, 0);
            checks++;
            if (Expired !== (e == 12) || (e == 4 && (Remaining !== 4'd2 || Busy !== 1'b1))) begin
                errors++;
                $display("FAIL prio_start edge %0d: got E=%b R=%0d B=%b", e, Expired, Remaining, Busy);
            end
        end
    endtask

    task automatic test_random();
        bit         st;
        bit         pg;
        logic [3:0] v;
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 15) == 0);
            pg = ($urandom_range(0, 40) == 0);
            v  = 4'($urandom_range(0, 4));
            step(st, v, pg);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b required %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        Start_Timer = 1'b0;
        value       = 4'd0;
        Prog_Sync   = 1'b0;
        model_reset();
        #23;
        rst_n = 1'b1;

        test_reset();
        test_basic();
        test_zero();
        test_restart();
        test_abort();
        test_priority();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
